hc_multi: RTL
=============

Name: hc_multi

Overview:
- Parametrised successor to the two-sensor hysteresis comparator. Tracks which of N_CH signed sensor channels is hottest.
- A channel takes over leadership only when it exceeds the current leader by more than a runtime threshold, and only after holding that margin for a programmable dwell of valid samples.
- Sits between the sensor sample registers and the thermal-management control logic. Supplies a leader index, a one-hot leader vector and a change pulse.

Parameters:
- N_CH, 4, number of sensor channels (>=2).
- W, 8, sample width in bits, signed two's complement.
- CNT_W, 4, width of the dwell counter and of the dwell port.
- IDX_W, $clog2(N_CH), leader index width (derived; not overridden).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  high when samples are a valid sample set this cycle.
- samples  in  N_CH*W  packed signed samples; channel k occupies bits [k*W +: W].
- th  in  W  unsigned hysteresis threshold, sampled every cycle.
- dwell  in  CNT_W  consecutive qualifying valid samples required to switch; 0 is treated as 1.
- leader  out  IDX_W  index of the current hottest channel.
- leader_oh  out  N_CH  one-hot of leader; all zero while out_valid=0.
- out_valid  out  1  high once the leader has been initialised.
- changed  out  1  one-cycle pulse on the cycle after leader switches.
- pending  out  1  high while a challenger's dwell count is non-zero.

Behaviour:
- Reset (rst_n=0 at posedge): leader=0, leader_oh=0, out_valid=0, changed=0, pending=0, dwell count=0, pending index=0. Reset mid-dwell discards the challenge.
- Arithmetic:
  - Every comparison is made after sign-extending samples to W+2 bits and zero-extending th to W+2 bits. No wrap is permitted.
  - cand = argmax over channels of sample value; ties go to the lowest index. Combinational.
  - lv = sample of the current leader channel.
- in_valid=0: all state holds; changed=0. The dwell count is neither cleared nor advanced.
- Init: the first in_valid cycle after reset sets leader=cand and out_valid=1 with no hysteresis and no dwell. changed stays 0 on this event.
- Once initialised, on each in_valid cycle:
  - qual = (cand != leader) && (samples[cand] > lv + th). The comparison is strict.
  - If qual is false: count <= 0, pending falls.
  - If qual is true:
    - eff = (cand == pend_idx && count != 0) ? count+1 : 1.
    - If eff >= max(dwell,1): leader <= cand, count <= 0, changed <= 1 for exactly one cycle.
    - Otherwise: pend_idx <= cand, count <= eff.
  - A different challenger appearing mid-dwell restarts the count at 1 for the new channel.
- Latency: outputs are registered. leader, leader_oh and changed update at the posedge that samples the qualifying in_valid cycle.
- count saturates at 2^CNT_W-1. It cannot wrap, because a switch occurs no later than count reaching dwell.
- dwell and th may change at any time. The new values apply to the current cycle's comparison, and the existing count is kept.
- leader_oh always equals (1<<leader) when out_valid=1.

Test Plan:
All tests use N_CH=4, W=8, th=5, dwell=3.
- Init: reset for 2 cycles, then samples={ch0..3: 10,20,30,25}, in_valid=1 -> next cycle out_valid=1, leader=2, leader_oh=0100, changed=0. Also samples all 7 at init -> leader=0.
- Hysteresis: leader=2 at 30; ch3=35 for 10 valid cycles -> no switch, pending=0. Then ch3=36 for 3 valid cycles -> leader=3 after the third sample, leader_oh=1000, changed high exactly 1 cycle, pending cleared.
- Dwell interrupt and restart:
  - ch3=36 for 2 cycles, then 30 for 1 cycle, then 36 for 2 cycles -> no switch; pending drops after the interruption.
  - ch1=40 appears while ch3 has count 2 -> count restarts; switch to ch1 only after 3 cycles.
- Stall and reset: ch3=36 for 2 cycles, in_valid=0 for 5 cycles, ch3=36 for 1 cycle -> switch on that cycle. Repeat, but with rst_n=0 for 1 cycle mid-dwell -> out_valid=0, leader=0, count cleared, re-initialises on the next valid sample.
- Overflow edges:
  - Leader ch0=125, th=5, ch1=127 -> no switch (no wrap).
  - Leader ch0=-128, ch1=127, th=255 -> no switch (127 > 127 false); th=254 -> switch after 3 cycles.
- dwell=0 and dwell=1: a qualifying challenger switches on the first qualifying valid sample, and changed pulses once.

Source files
------------

// File: rtl/hc_multi.sv
// Hottest-channel tracker with hysteresis threshold and dwell qualification.
// A challenger must beat the leader by more than th for dwell consecutive valid samples.
module hc_multi #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned IDX_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    input  logic [N_CH*W-1:0] i_samples,
    input  logic [W-1:0]      i_th,
    input  logic [CNT_W-1:0]  i_dwell,
    output logic [IDX_W-1:0]  o_leader,
    output logic [N_CH-1:0]   o_leader_oh,
    output logic              o_out_valid,
    output logic              o_changed,
    output logic              o_pending
);

    localparam int unsigned EW = W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0]     r_leader, w_leader_nxt;
    logic [IDX_W-1:0]     r_pend_idx, w_pend_idx_nxt;
    logic [N_CH-1:0]      r_leader_oh, w_leader_oh_nxt;
    logic                 r_out_valid, w_out_valid_nxt;
    logic                 r_changed, w_changed_nxt;
    logic                 r_pending, w_pending_nxt;
    logic [CNT_W-1:0]     r_count, w_count_nxt;

    logic [IDX_W-1:0]     w_cand;
    logic signed [EW-1:0] w_cand_val;
    logic signed [EW-1:0] w_lv;
    logic signed [EW-1:0] w_lim;
    logic                 w_qual;
    logic [CNT_W-1:0]     w_dwell_eff;
    logic [CNT_W-1:0]     w_eff;

    // Widen before comparing so leader + th can never wrap.
    function automatic logic signed [EW-1:0] sext(input logic [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    // Argmax over channels; strict > keeps ties on the lowest index.
    always_comb begin
        w_cand     = '0;
        w_cand_val = sext(i_samples[W-1:0]);
        for (int k = 1; k < N_CH; k++) begin
            if (sext(i_samples[k*W +: W]) > w_cand_val) begin
                w_cand_val = sext(i_samples[k*W +: W]);
                w_cand     = IDX_W'(k);
            end
        end
    end

    assign w_lv        = sext(i_samples[r_leader*W +: W]);
    assign w_lim       = w_lv + $signed({2'b00, i_th});
    assign w_qual      = (w_cand != r_leader) && (w_cand_val > w_lim);
    assign w_dwell_eff = (i_dwell == '0) ? CNT_W'(1) : i_dwell;
    assign w_eff       = (w_cand == r_pend_idx && r_count != '0)
                       ? ((r_count == CNT_MAX) ? CNT_MAX : r_count + CNT_W'(1))
                       : CNT_W'(1);

    always_comb begin
        w_leader_nxt    = r_leader;
        w_leader_oh_nxt = r_leader_oh;
        w_pend_idx_nxt  = r_pend_idx;
        w_out_valid_nxt = r_out_valid;
        w_count_nxt     = r_count;
        w_changed_nxt   = 1'b0;
        if (i_in_valid) begin
            if (!r_out_valid) begin
                w_leader_nxt    = w_cand;
                w_leader_oh_nxt = N_CH'(1) << w_cand;
                w_out_valid_nxt = 1'b1;
            end else if (!w_qual) begin
                w_count_nxt = '0;
            end else if (w_eff >= w_dwell_eff) begin
                w_leader_nxt    = w_cand;
                w_leader_oh_nxt = N_CH'(1) << w_cand;
                w_count_nxt     = '0;
                w_changed_nxt   = 1'b1;
            end else begin
                w_pend_idx_nxt = w_cand;
                w_count_nxt    = w_eff;
            end
        end
        w_pending_nxt = (w_count_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_leader    <= '0;
            r_leader_oh <= '0;
            r_pend_idx  <= '0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_changed   <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_leader    <= w_leader_nxt;
            r_leader_oh <= w_leader_oh_nxt;
            r_pend_idx  <= w_pend_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_count     <= w_count_nxt;
            r_changed   <= w_changed_nxt;
            r_pending   <= w_pending_nxt;
        end
    end

    assign o_leader    = r_leader;
    assign o_leader_oh = r_leader_oh;
    assign o_out_valid = r_out_valid;
    assign o_changed   = r_changed;
    assign o_pending   = r_pending;

endmodule
